// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - one-shot/periodic timer sequencer driving an external loadable up-counter
// Captures start/terminal values, loads and gates the counter, and reports expiries.
module timer_ctrl #(
    parameter int WIDTH   = 5,
    parameter int TALLY_W = 8
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               start,
    input  logic               stop,
    input  logic               periodic,
    input  logic [WIDTH-1:0]   start_val,
    input  logic [WIDTH-1:0]   term_val,
    input  logic               tick,
    input  logic               tally_clr,
    input  logic [WIDTH-1:0]   count,
    output logic               load,
    output logic [WIDTH-1:0]   data,
    output logic               enable,
    output logic               busy,
    output logic               expire,
    output logic [TALLY_W-1:0] expire_tally
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   start_q, start_d;
    logic [WIDTH-1:0]   term_q, term_d;
    logic               periodic_q, periodic_d;
    logic               expire_q, expire_d;
    logic [TALLY_W-1:0] tally_q, tally_d;
    logic               hit;
    logic               capture;

    assign hit = (state_q == RUN) && (count == term_q);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= IDLE;
            start_q    <= '0;
            term_q     <= '0;
            periodic_q <= 1'b0;
            expire_q   <= 1'b0;
            tally_q    <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            term_q     <= term_d;
            periodic_q <= periodic_d;
            expire_q   <= expire_d;
            tally_q    <= tally_d;
        end
    end

    // stop outranks start, and both outrank an expiry in RUN
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        expire_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    capture = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: state_d = stop ? IDLE : RUN;
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    capture = 1'b1;
                    state_d = LOAD;
                end else if (hit) begin
                    expire_d = 1'b1;
                    state_d  = periodic_q ? LOAD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        start_d    = capture ? start_val : start_q;
        term_d     = capture ? term_val  : term_q;
        periodic_d = capture ? periodic  : periodic_q;

        tally_d = tally_q;
        if (tally_clr) begin
            tally_d = '0;
        end else if (expire_q && (tally_q != {TALLY_W{1'b1}})) begin
            tally_d = tally_q + 1'b1;
        end
    end

    always_comb begin
        load         = (state_q == LOAD);
        busy         = (state_q != IDLE);
        enable       = (state_q == RUN) && tick && !hit && !stop && !start;
        data         = start_q;
        expire       = expire_q;
        expire_tally = tally_q;
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - scoreboard bench for timer_ctrl with a behavioural counter model
module tb_timer_ctrl;
    localparam int W  = 5;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst_ = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          periodic = 1'b0;
    logic          tally_clr = 1'b0;
    logic          tick;
    logic [W-1:0]  start_val = '0;
    logic [W-1:0]  term_val = '0;
    logic [W-1:0]  count;
    logic          load, enable, busy, expire;
    logic [W-1:0]  data;
    logic [TW-1:0] expire_tally;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    bit tick3 = 1'b0;
    int n;
    int m;

    typedef struct {
        int           cyc;
        logic [W-1:0] cnt;
    } exp_t;
    exp_t sb[$];
    exp_t e_m;

    timer_ctrl #(.WIDTH(W), .TALLY_W(TW)) dut (
        .clk(clk), .rst_(rst_), .start(start), .stop(stop), .periodic(periodic),
        .start_val(start_val), .term_val(term_val), .tick(tick), .tally_clr(tally_clr),
        .count(count), .load(load), .data(data), .enable(enable), .busy(busy),
        .expire(expire), .expire_tally(expire_tally)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign tick = tick3 ? (cyc % 3 == 0) : 1'b1;

    // external loadable up-counter: load has priority over enable
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)       count <= '0;
        else if (load)   count <= data;
        else if (enable) count <= count + 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (expire) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_expire: got expire=1, expected none (cycle %0d)", cyc);
            end else begin
                e_m = sb.pop_front();
                chk("expire_cycle", cyc, e_m.cyc);
                chk("expire_count", count, e_m.cnt);
            end
        end
    end

    task automatic cyc_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic go(input logic [W-1:0] sv, input logic [W-1:0] tv, input logic per);
        start_val = sv;
        term_val  = tv;
        periodic  = per;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_load", load, 0);
        chk("rst_enable", enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_expire", expire, 0);
        chk("rst_data", data, 0);
        chk("rst_tally", expire_tally, 0);
        @(negedge clk);
        rst_ = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);

        // one-shot 3..7
        n = cyc;
        sb.push_back('{n + 7, 5'd7});
        go(3, 7, 0);
        #1;
        chk("os_load", load, 1);
        chk("os_load_en", enable, 0);
        cyc_to(n + 2);
        #1;
        chk("os_load_once", load, 0);
        chk("os_count_start", count, 3);
        chk("os_enable", enable, 1);
        cyc_to(n + 5);
        chk("os_count_6", count, 6);
        cyc_to(n + 6);
        #1;
        chk("os_count_term", count, 7);
        chk("os_enable_at_term", enable, 0);
        chk("os_busy_run", busy, 1);
        cyc_to(n + 7);
        chk("os_busy_done", busy, 0);
        cyc_to(n + 9);
        chk("os_count_hold", count, 7);
        chk("os_tally", expire_tally, 1);

        // start on the hit cycle restarts without expiring
        n = cyc;
        go(3, 7, 0);
        cyc_to(n + 6);
        sb.push_back('{n + 13, 5'd7});
        start = 1'b1;
        #1;
        chk("rh_enable", enable, 0);
        @(negedge clk);
        start = 1'b0;
        chk("rh_load", load, 1);
        cyc_to(n + 14);
        chk("rh_tally", expire_tally, 2);

        // periodic 3..7, three periods then stop
        n = cyc;
        sb.push_back('{n + 7, 5'd7});
        sb.push_back('{n + 13, 5'd7});
        sb.push_back('{n + 19, 5'd7});
        go(3, 7, 1);
        cyc_to(n + 7);
        chk("per_reload", load, 1);
        cyc_to(n + 8);
        chk("per_count_reload", count, 3);
        cyc_to(n + 20);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("per_stop_busy", busy, 0);
        cyc_to(n + 22);
        chk("per_stop_count", count, 3);
        chk("per_tally", expire_tally, 5);

        // wrap 30 -> 1 with tick every third cycle
        tick3 = 1'b1;
        @(negedge clk);
        while (cyc % 3 != 0) @(negedge clk);
        n = cyc;
        sb.push_back('{n + 11, 5'd1});
        go(30, 1, 0);
        cyc_to(n + 3);
        chk("wr_c30", count, 30);
        cyc_to(n + 4);
        chk("wr_c31", count, 31);
        cyc_to(n + 6);
        chk("wr_c31_hold", count, 31);
        cyc_to(n + 7);
        chk("wr_c0", count, 0);
        cyc_to(n + 10);
        chk("wr_c1", count, 1);
        cyc_to(n + 12);
        chk("wr_busy", busy, 0);
        chk("wr_tally", expire_tally, 6);
        tick3 = 1'b0;

        // stop together with start aborts
        @(negedge clk);
        n = cyc;
        go(3, 7, 0);
        cyc_to(n + 4);
        chk("ab_count5", count, 5);
        stop  = 1'b1;
        start = 1'b1;
        #1;
        chk("ab_enable", enable, 0);
        @(negedge clk);
        stop  = 1'b0;
        start = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_load", load, 0);
        cyc_to(n + 6);
        chk("ab_count_hold", count, 5);

        // start alone in RUN restarts
        m = cyc;
        go(3, 7, 0);
        cyc_to(m + 3);
        chk("rs_count4", count, 4);
        sb.push_back('{m + 10, 5'd7});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rs_load", load, 1);
        cyc_to(m + 5);
        chk("rs_count3", count, 3);
        cyc_to(m + 11);
        chk("rs_tally", expire_tally, 7);

        // start == term
        n = cyc;
        sb.push_back('{n + 3, 5'd9});
        go(9, 9, 0);
        cyc_to(n + 2);
        #1;
        chk("eq_count", count, 9);
        chk("eq_enable", enable, 0);
        cyc_to(n + 4);
        chk("eq_busy", busy, 0);
        chk("eq_tally", expire_tally, 8);

        // periodic start == term drives the tally into saturation; stop lands in LOAD
        n = cyc;
        for (int k = 0; k < 260; k++) sb.push_back('{n + 3 + 2 * k, 5'd9});
        go(9, 9, 1);
        cyc_to(n + 494);
        chk("sat_tally_254", expire_tally, 254);
        cyc_to(n + 521);
        chk("sat_in_load", load, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("sat_stop_busy", busy, 0);
        @(negedge clk);
        chk("sat_tally_255", expire_tally, 255);

        // asynchronous reset mid-run
        n = cyc;
        go(3, 31, 0);
        cyc_to(n + 6);
        #2;
        rst_ = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_load", load, 0);
        chk("ar_enable", enable, 0);
        chk("ar_expire", expire, 0);
        chk("ar_data", data, 0);
        chk("ar_tally", expire_tally, 0);
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
        repeat (3) @(negedge clk);
        chk("ar_idle", busy, 0);

        // tally_clr beats the increment from a simultaneous expire
        n = cyc;
        sb.push_back('{n + 3, 5'd9});
        go(9, 9, 0);
        cyc_to(n + 3);
        tally_clr = 1'b1;
        @(negedge clk);
        tally_clr = 1'b0;
        chk("clr_tally", expire_tally, 0);
        @(negedge clk);
        chk("clr_tally_hold", expire_tally, 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
